// File: rtl/hilo_capture_if.sv
// Bundle between the HI/LO capture block, the multiplier
// and the register-file bus.
interface hilo_capture_if;
  logic        start;
  logic [31:0] multiplicand_in;
  logic [31:0] multiplier_in;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [31:0] product_hi;
  logic [31:0] product_lo;
  logic        hi_write;
  logic        lo_write;
  logic [31:0] bus_in;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        done;
  logic        write_conflict;

  modport master (
    output start, multiplicand_in, multiplier_in,
    output product_hi, product_lo,
    output hi_write, lo_write, bus_in,
    input  multiplicand, multiplier,
    input  hi_out, lo_out,
    input  busy, done, write_conflict
  );

  modport slave (
    input  start, multiplicand_in, multiplier_in,
    input  product_hi, product_lo,
    input  hi_write, lo_write, bus_in,
    output multiplicand, multiplier,
    output hi_out, lo_out,
    output busy, done, write_conflict
  );
endinterface

// File: rtl/hilo_capture.sv
// HI/LO capture: holds operands for an external combinational
// multiplier, waits for it to settle, then latches the product.
module hilo_capture #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic           clock,
  input  logic           clear,
  hilo_capture_if.slave  io
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        wc_q, wc_d;
  logic        any_wr;

  assign any_wr = io.hi_write | io.lo_write;

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      wc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      wc_q     <= wc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    wc_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (io.start) begin
          mcand_d  = io.multiplicand_in;
          mplier_d = io.multiplier_in;
          cnt_d    = '0;
          state_d  = SETTLE;
        end
        if (io.hi_write) hi_d = io.bus_in;
        if (io.lo_write) lo_d = io.bus_in;
      end
      SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST) state_d = CAPTURE;
        wc_d = any_wr;
      end
      CAPTURE: begin
        // product is taken verbatim; signedness lives upstream
        hi_d    = io.product_hi;
        lo_d    = io.product_lo;
        done_d  = 1'b1;
        state_d = IDLE;
        wc_d    = any_wr;
      end
      default: state_d = IDLE;
    endcase
  end

  assign io.multiplicand   = mcand_q;
  assign io.multiplier     = mplier_q;
  assign io.hi_out         = hi_q;
  assign io.lo_out         = lo_q;
  assign io.busy           = (state_q != IDLE);
  assign io.done           = done_q;
  assign io.write_conflict = wc_q;

endmodule

// File: doc/hilo_capture.md
HILO_CAPTURE -- requirements
Module: hilo_capture

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2, setting the number of cycles allowed for the combinational booth_multiplier path to settle; legal range 1-15.
REQ-002 The block SHALL have port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port clear, input, 1 bit, reset: synchronous, active-low.
REQ-004 The block SHALL have port start, input, 1 bit, a request to begin a multiply.
REQ-005 The block SHALL have ports multiplicand_in and multiplier_in, input, 32 bits each, the operands, sampled only on an accepted start.
REQ-006 The block SHALL have ports multiplicand and multiplier, output, 32 bits each, the registered operands driven to booth_multiplier.
REQ-007 The block SHALL have ports product_hi and product_lo, input, 32 bits each, the signed 64-bit product returned from booth_multiplier.
REQ-008 The block SHALL have ports hi_write and lo_write, input, 1 bit each, direct-load strobes from the bus (move-to-HI/LO).
REQ-009 The block SHALL have port bus_in, input, 32 bits, the data for direct loads.
REQ-010 The block SHALL have ports hi_out and lo_out, output, 32 bits each, the contents of the HI and LO registers.
REQ-011 The block SHALL have port busy, output, 1 bit, high while a multiply is in flight.
REQ-012 The block SHALL have port done, output, 1 bit, a one-cycle pulse after HI/LO capture.
REQ-013 The block SHALL have port write_conflict, output, 1 bit, a one-cycle pulse when a direct load is rejected.

Function
REQ-014 The FSM SHALL have states IDLE, SETTLE and CAPTURE; busy = (state != IDLE), decoded combinationally from state.
REQ-015 In IDLE, start=1 SHALL register both operands, clear the settle counter to 0 and go to SETTLE.
REQ-016 In SETTLE, the counter SHALL increment every cycle; when the counter equals SETTLE_CYCLES-1 at an edge, the FSM SHALL go to CAPTURE.
REQ-017 In CAPTURE, one edge SHALL load hi_out<=product_hi and lo_out<=product_lo, set done=1 and return to IDLE.
REQ-018 Latency: with start accepted at edge E0, HI/LO SHALL update at edge E0+SETTLE_CYCLES+1 and done SHALL be high for exactly the following cycle.
REQ-019 start while busy SHALL be ignored: operands and counter unchanged, no queuing.
REQ-020 The operand registers SHALL hold their values from acceptance until the next accepted start, including after done.
REQ-021 hi_write/lo_write in IDLE SHALL load bus_in into HI/LO at that edge; both strobes together SHALL load both registers.
REQ-022 hi_write or lo_write while busy SHALL be dropped, HI/LO SHALL be unchanged and write_conflict SHALL pulse for one cycle.
REQ-023 A direct load and a start in the same IDLE cycle SHALL both take effect; the later capture SHALL overwrite the direct-loaded value.
REQ-024 A start in the cycle where done=1 (state IDLE) SHALL be accepted normally, giving back-to-back operation.
REQ-025 Product width SHALL be a signed 64-bit two's-complement value; the block SHALL not modify, sign-extend or truncate product bits.
REQ-026 The settle counter SHALL be 4 bits and SHALL never wrap during legal operation.

Reset
REQ-027 With clear=0 at an edge, the block SHALL set state=IDLE, counter=0, multiplicand=0, multiplier=0, hi_out=0, lo_out=0, done=0 and write_conflict=0.
REQ-028 Reset SHALL dominate start, hi_write and lo_write in the same cycle.
REQ-029 Reset mid-operation (SETTLE or CAPTURE) SHALL abort with no HI/LO update and no done pulse.

Verification
REQ-030 The bench SHALL pair the block with booth_multiplier at SETTLE_CYCLES=2; operands 2 x 4 -> at E0+3, hi_out=0x00000000, lo_out=0x00000008; done high one cycle.
REQ-031 The bench SHALL check sign handling: -2 x 4 -> hi_out=0xFFFFFFFF, lo_out=0xFFFFFFF8; 0x80000000 x 2 -> hi_out=0xFFFFFFFF, lo_out=0x00000000.
REQ-032 The bench SHALL check start while busy: 10 x 4 accepted, then 7 x 7 asserted in SETTLE -> result lo_out=40, hi_out=0, multiplicand stays 10, one done only.
REQ-033 The bench SHALL check direct loads: in IDLE, hi_write with bus_in=0x12345678 -> hi_out=0x12345678 next edge; lo_write during SETTLE -> lo_out unchanged and write_conflict pulses once.
REQ-034 The bench SHALL check reset mid-operation: start 3 x 5, clear=0 in SETTLE -> all outputs 0, busy=0, no done; a subsequent 3 x 5 yields lo_out=15.
REQ-035 The bench SHALL check back-to-back operation: a start asserted during the done cycle -> second result captured SETTLE_CYCLES+1 edges later, with no lost cycle.
